// File: rtl/regmst_apb_bridge.sv
// APB4 completer to reg_native_if requester: one APB transfer -> one req/ack exchange.
// Optional watchdog that ends unacknowledged transfers with pslverr, enabled by REGMST_TIMEOUT_EN.
module regmst_apb_bridge #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld,
    input  logic                  req_rdy,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ack_vld,
    output logic                  ack_rdy,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  write_q, write_d;
    logic                  ack_rdy_q, ack_rdy_d;
    logic                  ack_take;

`ifdef REGMST_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy;
`endif

    // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        write_d   = write_q;
        prdata_d  = prdata_q;
        ack_take  = 1'b0;
`ifdef REGMST_TIMEOUT_EN
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d    = paddr;
                    wr_data_d = pwdata;
                    write_d   = pwrite;
                    state_d   = REQ;
`ifdef REGMST_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            REQ: begin
                if (req_rdy && ack_vld) ack_take = 1'b1;
                else if (req_rdy)       state_d  = WAIT_ACK;
            end
            WAIT_ACK: ack_take = ack_vld;
            RESP:     state_d  = IDLE;
            default:  state_d  = IDLE;
        endcase

        // A genuine completion beats a watchdog expiry in the same cycle.
        if (ack_take) begin
            state_d  = RESP;
            prdata_d = write_q ? '0 : rd_data;
        end
`ifdef REGMST_TIMEOUT_EN
        else if (busy && cnt_q == CNT_MAX) begin
            state_d  = RESP;
            err_d    = 1'b1;
            prdata_d = ERR_DATA;
        end
`endif

        // Registered so ack_rdy stays low throughout reset and rises on the first IDLE cycle.
        ack_rdy_d = (state_d != RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            ack_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            ack_rdy_q <= ack_rdy_d;
        end
    end

`ifdef REGMST_TIMEOUT_EN
    assign busy = (state_q == REQ) || (state_q == WAIT_ACK);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)              cnt_d = '0;
        else if (busy && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign pslverr = (state_q == RESP) && err_q;
`else
    assign pslverr = 1'b0;
`endif

    assign pready  = (state_q == RESP);
    assign req_vld = (state_q == REQ);
    assign wr_en   = req_vld && write_q;
    assign rd_en   = req_vld && !write_q;
    assign addr    = addr_q;
    assign wr_data = wr_data_q;
    assign prdata  = prdata_q;
    assign ack_rdy = ack_rdy_q;

endmodule

// File: tb/tb_regmst_apb_bridge.sv
// Directed bench for regmst_apb_bridge; the watchdog scenario runs when REGMST_TIMEOUT_EN is defined.
module tb_regmst_apb_bridge;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [63:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        req_vld, wr_en, rd_en, ack_rdy;
    logic        req_rdy = 1'b0, ack_vld = 1'b0;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data = '0;

    int tests  = 0;
    int failed = 0;

    regmst_apb_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .req_vld(req_vld), .req_rdy(req_rdy), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .ack_vld(ack_vld), .ack_rdy(ack_rdy), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // {pready, pslverr, req_vld, wr_en, rd_en, ack_rdy}
    wire [5:0] st = {pready, pslverr, req_vld, wr_en, rd_en, ack_rdy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic w, input logic [63:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
    endtask

    task automatic apb_idle();
        psel = 1'b0; penable = 1'b0;
        req_rdy = 1'b0; ack_vld = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        tests++;
        if (st !== 6'b000000) begin failed++; $display("FAIL reset_status got %b exp %b", st, 6'b000000); end
        tests++;
        if ({addr, wr_data, prdata} !== 128'h0) begin
            failed++; $display("FAIL reset_data got %h %h %h exp 0", addr, wr_data, prdata);
        end
        rstn = 1'b1;
        #1;
        tests++;
        if (ack_rdy !== 1'b0) begin failed++; $display("FAIL ack_rdy_before_edge got %b exp 0", ack_rdy); end
        step();
        tests++;
        if (st !== 6'b000001) begin failed++; $display("FAIL first_idle got %b exp %b", st, 6'b000001); end
    endtask

    task automatic test_write_immediate();
        setup(1'b1, 64'h0, 32'hFFFF_FFFF);
        tests++;
        if (st !== 6'b001101 || wr_data !== 32'hFFFF_FFFF || addr !== 64'h0) begin
            failed++; $display("FAIL wr_req got st=%b wd=%h a=%h exp st=001101 wd=ffffffff a=0", st, wr_data, addr);
        end
        req_rdy = 1'b1; ack_vld = 1'b1;
        step();
        tests++;
        if (st !== 6'b100000 || prdata !== 32'h0) begin
            failed++; $display("FAIL wr_resp got st=%b prdata=%h exp st=100000 prdata=0", st, prdata);
        end
        apb_idle();
        step();
        tests++;
        if (st !== 6'b000001) begin failed++; $display("FAIL wr_single_pready got %b exp 000001", st); end
    endtask

    task automatic test_read_delayed();
        setup(1'b0, 64'h0, 32'h0);
        tests++;
        if (st !== 6'b001011) begin failed++; $display("FAIL rd_req got %b exp 001011", st); end
        req_rdy = 1'b1;
        step();
        req_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (st !== 6'b000001 || prdata !== 32'h0) begin
                failed++; $display("FAIL rd_wait%0d got st=%b prdata=%h exp st=000001 prdata=0", i, st, prdata);
            end
            step();
        end
        ack_vld = 1'b1; rd_data = 32'h1234_5678;
        step();
        tests++;
        if (st !== 6'b100000 || prdata !== 32'h1234_5678) begin
            failed++; $display("FAIL rd_resp got st=%b prdata=%h exp st=100000 prdata=12345678", st, prdata);
        end
        apb_idle(); rd_data = 32'h0;
        step();
        tests++;
        if (st !== 6'b000001 || prdata !== 32'h1234_5678) begin
            failed++; $display("FAIL rd_hold got st=%b prdata=%h exp st=000001 prdata=12345678", st, prdata);
        end
    endtask

    task automatic test_backpressure();
        setup(1'b1, 64'h0000_0001_0000_0040, 32'hA5A5_5A5A);
        // psel drops mid-transfer; the exchange must still complete.
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({req_vld, wr_en, rd_en} !== 3'b110 || addr !== 64'h0000_0001_0000_0040 ||
                wr_data !== 32'hA5A5_5A5A) begin
                failed++;
                $display("FAIL bp_stable%0d got v/w/r=%b a=%h wd=%h exp 110 a=0000000100000040 wd=a5a55a5a",
                         i, {req_vld, wr_en, rd_en}, addr, wr_data);
            end
            step();
        end
        req_rdy = 1'b1;
        step();
        req_rdy = 1'b0;
        tests++;
        if (st !== 6'b000001) begin failed++; $display("FAIL bp_req_drop got %b exp 000001", st); end
        ack_vld = 1'b1;
        step();
        tests++;
        if (st !== 6'b100000) begin failed++; $display("FAIL bp_resp got %b exp 100000", st); end
        apb_idle();
        step();
    endtask

    task automatic test_reset_mid();
        setup(1'b1, 64'h80, 32'h0BAD_F00D);
        req_rdy = 1'b1;
        step();
        req_rdy = 1'b0;
        tests++;
        if (st !== 6'b000001 || addr !== 64'h80) begin
            failed++; $display("FAIL rm_wait got st=%b a=%h exp st=000001 a=80", st, addr);
        end
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (st !== 6'b000000 || {addr, wr_data, prdata} !== 128'h0) begin
            failed++; $display("FAIL rm_async got st=%b a=%h wd=%h pd=%h exp all 0", st, addr, wr_data, prdata);
        end
        ack_vld = 1'b1;
        step();
        apb_idle();
        rstn = 1'b1;
        ack_vld = 1'b1;
        step();
        ack_vld = 1'b0;
        step();
        tests++;
        if (st !== 6'b000001) begin failed++; $display("FAIL rm_drain got %b exp 000001", st); end
        setup(1'b1, 64'h84, 32'h1357_9BDF);
        tests++;
        if (st !== 6'b001101 || wr_data !== 32'h1357_9BDF) begin
            failed++; $display("FAIL rm_fresh_req got st=%b wd=%h exp st=001101 wd=13579bdf", st, wr_data);
        end
        req_rdy = 1'b1; ack_vld = 1'b1;
        step();
        tests++;
        if (st !== 6'b100000) begin failed++; $display("FAIL rm_fresh_resp got %b exp 100000", st); end
        apb_idle();
        step();
    endtask

    task automatic test_back_to_back();
        setup(1'b1, 64'h10, 32'h1111_1111);
        req_rdy = 1'b1; ack_vld = 1'b1;
        step();
        req_rdy = 1'b0; ack_vld = 1'b0;
        tests++;
        if (st !== 6'b100000) begin failed++; $display("FAIL b2b_first_resp got %b exp 100000", st); end
        step();
        tests++;
        if (st !== 6'b000001) begin failed++; $display("FAIL b2b_gap got %b exp 000001", st); end
        setup(1'b0, 64'h14, 32'h0);
        tests++;
        if (st !== 6'b001011 || addr !== 64'h14) begin
            failed++; $display("FAIL b2b_second_req got st=%b a=%h exp st=001011 a=14", st, addr);
        end
        req_rdy = 1'b1; ack_vld = 1'b1; rd_data = 32'hCAFE_F00D;
        step();
        tests++;
        if (st !== 6'b100000 || prdata !== 32'hCAFE_F00D) begin
            failed++; $display("FAIL b2b_second_resp got st=%b prdata=%h exp st=100000 prdata=cafef00d", st, prdata);
        end
        apb_idle(); rd_data = 32'h0;
        step();
    endtask

`ifdef REGMST_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        setup(1'b0, 64'h20, 32'h0);
        while (pready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (n !== 9) begin failed++; $display("FAIL to_latency got %0d exp 9", n); end
        tests++;
        if (st !== 6'b110000 || prdata !== 32'hDEAD_BEEF) begin
            failed++; $display("FAIL to_resp got st=%b prdata=%h exp st=110000 prdata=deadbeef", st, prdata);
        end
        apb_idle();
        repeat (20) step();
        ack_vld = 1'b1;
        step();
        ack_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (st !== 6'b000001) begin failed++; $display("FAIL to_late_ack%0d got %b exp 000001", i, st); end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_immediate();
        test_read_delayed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef REGMST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got hang exp finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/regmst_apb_bridge.md
# regmst_apb_bridge

APB4 completer to reg_native_if requester bridge. It sits directly upstream of the generated regslv_* register blocks and converts one APB transfer into exactly one reg_native_if request/acknowledge exchange. The bridge returns read data and error status on the APB side. An optional watchdog terminates transfers that the regslv chain never acknowledges.

## Interface
- ADDR_WIDTH, 64, address width on both sides.
- DATA_WIDTH, 32, data width on both sides.
- TIMEOUT_CYCLES, 256, watchdog limit in clk cycles (compiled in only with the macro).
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  APB address.
- pwdata  in  DATA_WIDTH  APB write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data (registered).
- pslverr  out  1  transfer error.
- req_vld  out  1  downstream request valid.
- req_rdy  in  1  downstream request accepted.
- wr_en  out  1  write request, held with req_vld.
- rd_en  out  1  read request, held with req_vld.
- addr  out  ADDR_WIDTH  request address.
- wr_data  out  DATA_WIDTH  request write data.
- ack_vld  in  1  downstream acknowledge valid.
- ack_rdy  out  1  bridge ready for the acknowledge.
- rd_data  in  DATA_WIDTH  downstream read data, valid with ack_vld.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RESP. Reset state is IDLE.
- IDLE:
  - Entered on the APB setup phase (psel & !penable).
  - Registers paddr, pwdata and pwrite into addr, wr_data and direction, then moves to REQ.
  - ack_rdy=1 in IDLE, so any stray acknowledge is accepted and discarded.
- REQ:
  - Drives req_vld=1, plus wr_en=pwrite or rd_en=!pwrite.
  - addr, wr_data, wr_en and rd_en stay stable until req_rdy is sampled high.
  - ack_rdy=1.
  - On req_rdy & ack_vld in the same cycle, go to RESP. On req_rdy alone, go to WAIT_ACK.
- WAIT_ACK:
  - req_vld=0, wr_en=0, rd_en=0, ack_rdy=1.
  - On ack_vld, go to RESP.
- Data capture:
  - On the accepting ack_vld of a read, rd_data is registered into prdata.
  - On a write, prdata is 0.
- RESP:
  - pready=1 for exactly one cycle, then back to IDLE.
  - pslverr=0 unless the watchdog fired.
- Outputs outside these states:
  - pready, pslverr and req_vld are 0 in all other states.
  - prdata holds its value until the next capture.
- Exactly one outstanding request at a time. A new setup phase is only recognised in IDLE.
- If psel drops mid-transfer (APB violation), the bridge still completes the downstream exchange and issues its single pready cycle. There is no cancellation.
- Reset mid-operation:
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - A pending downstream ack after reset is drained through the IDLE ack_rdy.

## Timing
- Setup phase at cycle T0. REQ with req_vld=1 at T1.
- Best case (req_rdy and ack_vld both at T1): pready at T2, one APB wait state.
- General case: pready one cycle after the accepting ack_vld.
- Reset values of all outputs: pready=0, prdata=0, pslverr=0, req_vld=0, wr_en=0, rd_en=0, addr=0, wr_data=0, ack_rdy=0 while rstn is low.
  - ack_rdy becomes 1 in the first IDLE cycle after reset release.

## Configuration
- REGMST_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears when REQ is entered and increments every cycle in REQ and WAIT_ACK.
  - The counter saturates; it does not wrap.
  - When it reaches TIMEOUT_CYCLES without completion, req_vld drops and the FSM goes to RESP with pslverr=1 and prdata=32'hDEAD_BEEF (truncated or zero-extended to DATA_WIDTH).
  - A late ack arriving afterwards is discarded in IDLE.
  - A completion on the same cycle as expiry wins, with normal response and pslverr=0.
- REGMST_TIMEOUT_EN undefined:
  - No counter. The bridge waits indefinitely.
  - pslverr is constant 0.

## Test plan
- APB write addr 0x0, data 0xFFFF_FFFF, regslv stub acks immediately -> one req_vld pulse with wr_en=1 and wr_data=0xFFFF_FFFF; pready at T2 with pslverr=0.
- APB read of the same address, stub returns rd_data=0x1234_5678 after 3 cycles -> prdata=0x1234_5678 in the pready cycle; rd_en high only while req_vld is high.
- Stub holds req_rdy low for 5 cycles -> addr, wr_en and wr_data stable throughout; req_vld deasserts the cycle after req_rdy.
- REGMST_TIMEOUT_EN with TIMEOUT_CYCLES=8, stub never acks a read -> pready with pslverr=1 and prdata=0xDEAD_BEEF; a late ack_vld 20 cycles later is absorbed and causes no pready.
- rstn asserted while in WAIT_ACK -> all outputs 0 asynchronously; after release, a fresh write completes normally.
- Back-to-back APB transfers (setup immediately after pready) -> second req_vld rises at T1 of the new transfer, with no overlap with the previous exchange.
